// File: rtl/bias_activation.sv
// bias_activation
//   Post-accumulation stage: adds the per-kernel bias to each signed accumulator
//   result, applies ReLU, right-shifts by SHIFT and saturates to OUT_WIDTH bits.
//   Counts accepted pixels per kernel and pulses next_bias_o so the bias buffer
//   advances to the next kernel's bias.
//
//   Optional feature macro: BIAS_ACT_ROUND_EN
//     defined   -> round-half-up (add 2^(SHIFT-1) before the shift)
//     undefined -> truncating (floor) shift
//
// Ports
//   clock_i       : clock, rising edge
//   reset_i       : asynchronous active-low reset
//   acc_valid_i   : accumulator beat valid
//   acc_ready_o   : stage accepts a beat this cycle (combinational, = !stall)
//   acc_data_i    : signed accumulator value
//   bias_i        : signed bias for the current kernel
//   out_valid_o   : output pixel valid
//   out_ready_i   : downstream accepts pixel
//   out_data_o    : activated, scaled, saturated pixel
//   kernel_idx_o  : kernel of the beat currently being accepted
//   next_bias_o   : one-cycle pulse after the last pixel of a kernel is accepted
//   done_o        : one-cycle pulse after the last pixel of the last kernel
module bias_activation #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned N_PIXELS   = 676,
  parameter int unsigned N_KERNELS  = 32
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         acc_valid_i,
  output logic                         acc_ready_o,
  input  logic [DATA_WIDTH-1:0]        acc_data_i,
  input  logic [DATA_WIDTH-1:0]        bias_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [OUT_WIDTH-1:0]         out_data_o,
  output logic [$clog2(N_KERNELS)-1:0] kernel_idx_o,
  output logic                         next_bias_o,
  output logic                         done_o
);

  localparam int unsigned SUM_W = DATA_WIDTH + 1;
  localparam int unsigned KW    = $clog2(N_KERNELS);
  localparam int unsigned PW    = $clog2(N_PIXELS);
`ifdef BIAS_ACT_ROUND_EN
  localparam int unsigned RND_W = SUM_W + 1;
  localparam logic [RND_W-1:0] HALF = RND_W'(1) << (SHIFT - 1);
`else
  localparam int unsigned RND_W = SUM_W;
`endif

  // Pipeline state
  logic             r_s1_valid;
  logic [SUM_W-1:0] r_s1_sum;
  logic             r_out_valid;
  logic [OUT_WIDTH-1:0] r_out_data;

  // Counters and pulses
  logic [PW-1:0] r_pix;
  logic [KW-1:0] r_kernel;
  logic          r_next_bias;
  logic          r_done;

  logic             w_stall;
  logic             w_accept;
  logic [SUM_W-1:0] w_sum;
  logic [RND_W-1:0] w_rnd;
  logic [RND_W-1:0] w_q;
  logic [OUT_WIDTH-1:0] w_act;
  logic          w_last_pix;
  logic          w_last_kernel;

  assign w_stall     = r_out_valid && !out_ready_i;
  assign acc_ready_o = !w_stall;
  assign w_accept    = acc_valid_i && !w_stall;

  // Sign-extended add one bit wider than the operands, so it cannot overflow
  assign w_sum = {acc_data_i[DATA_WIDTH-1], acc_data_i} + {bias_i[DATA_WIDTH-1], bias_i};

  always_comb begin
    w_rnd = '0;
    w_q   = '0;
    w_act = '0;
`ifdef BIAS_ACT_ROUND_EN
    w_rnd = {r_s1_sum[SUM_W-1], r_s1_sum} + HALF;
`else
    w_rnd = r_s1_sum;
`endif
    // Logical shift is enough: negative values are clamped before use
    w_q = w_rnd >> SHIFT;
    if (w_rnd[RND_W-1]) begin
      w_act = '0;
    end else if (|w_q[RND_W-1:OUT_WIDTH]) begin
      w_act = '1;
    end else begin
      w_act = w_q[OUT_WIDTH-1:0];
    end
  end

  // Both stages advance together whenever the output is not stalled
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_s1_valid  <= 1'b0;
      r_s1_sum    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (!w_stall) begin
      r_s1_valid  <= acc_valid_i;
      if (acc_valid_i) begin
        r_s1_sum <= w_sum;
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_act;
      end
    end
  end

  assign w_last_pix    = (r_pix == PW'(N_PIXELS - 1));
  assign w_last_kernel = (r_kernel == KW'(N_KERNELS - 1));

  // Counters follow input acceptance, so pulses are never delayed by backpressure
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_pix       <= '0;
      r_kernel    <= '0;
      r_next_bias <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_next_bias <= 1'b0;
      r_done      <= 1'b0;
      if (w_accept) begin
        if (w_last_pix) begin
          r_pix       <= '0;
          r_next_bias <= 1'b1;
          if (w_last_kernel) begin
            r_kernel <= '0;
            r_done   <= 1'b1;
          end else begin
            r_kernel <= r_kernel + KW'(1);
          end
        end else begin
          r_pix <= r_pix + PW'(1);
        end
      end
    end
  end

  assign out_valid_o  = r_out_valid;
  assign out_data_o   = r_out_data;
  assign kernel_idx_o = r_kernel;
  assign next_bias_o  = r_next_bias;
  assign done_o       = r_done;

endmodule

// File: tb/tb_bias_activation.sv
// Directed bench for bias_activation (N_PIXELS=4, N_KERNELS=2 for short frames).
module tb_bias_activation;

  logic        clock_i;
  logic        reset_i;
  logic        acc_valid_i;
  logic        acc_ready_o;
  logic [31:0] acc_data_i;
  logic [31:0] bias_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  out_data_o;
  logic [0:0]  kernel_idx_o;
  logic        next_bias_o;
  logic        done_o;

  int n_checks = 0;
  int n_errors = 0;

  bias_activation #(
    .DATA_WIDTH (32),
    .OUT_WIDTH  (8),
    .SHIFT      (8),
    .N_PIXELS   (4),
    .N_KERNELS  (2)
  ) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .acc_valid_i  (acc_valid_i),
    .acc_ready_o  (acc_ready_o),
    .acc_data_i   (acc_data_i),
    .bias_i       (bias_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .kernel_idx_o (kernel_idx_o),
    .next_bias_o  (next_bias_o),
    .done_o       (done_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    tick();
    reset_i = 1'b1;
    tick();
  endtask

  // Single beat with ready high: result two edges after it is presented, valid one cycle
  task automatic send_one(input string tag, input logic [31:0] acc, input logic [31:0] bias,
                          input logic [7:0] exp);
    acc_valid_i = 1'b1;
    acc_data_i  = acc;
    bias_i      = bias;
    tick();
    acc_valid_i = 1'b0;
    chk({tag, "_v0"}, out_valid_o, 1'b0);
    tick();
    chk({tag, "_v1"}, out_valid_o, 1'b1);
    chk(tag, out_data_o, exp);
    tick();
    chk({tag, "_v2"}, out_valid_o, 1'b0);
  endtask

  logic [7:0] round_exp;
  int sent;
  int recv;
  logic acc_ok;

  initial begin
    reset_i     = 1'b0;
    acc_valid_i = 1'b0;
    acc_data_i  = '0;
    bias_i      = '0;
    out_ready_i = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_out_data", out_data_o, 8'd0);
    chk("rst_kernel", kernel_idx_o, 1'b0);
    chk("rst_next_bias", next_bias_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_acc_ready", acc_ready_o, 1'b1);
    reset_i = 1'b1;
    tick();

    // Arithmetic vectors
    send_one("basic", 32'd1000, 32'd24, 8'd4);
    send_one("relu", -32'sd5000, 32'd100, 8'd0);
    send_one("sat", 32'd100000, 32'd0, 8'd255);
    send_one("nowrap", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 8'd255);
    send_one("negmax", 32'h8000_0000, 32'h8000_0000, 8'd0);
`ifdef BIAS_ACT_ROUND_EN
    round_exp = 8'd2;
`else
    round_exp = 8'd1;
`endif
    send_one("round384", 32'd384, 32'd0, round_exp);
    send_one("round383", 32'd383, 32'd0, 8'd1);

    // Stream of 10 beats with downstream stalled for cycles 4..6
    sent = 0;
    recv = 0;
    for (int c = 0; c < 60 && recv < 10; c++) begin
      out_ready_i = !(c >= 4 && c <= 6);
      acc_valid_i = (sent < 10);
      acc_data_i  = 32'((sent + 1) * 256 + 5);
      bias_i      = '0;
      #1;
      if (c < 10) chk("stream_ready", acc_ready_o, (c >= 4 && c <= 6) ? 1'b0 : 1'b1);
      if (out_valid_o) chk("stream_data", out_data_o, 64'(recv + 1));
      if (out_valid_o && out_ready_i) recv++;
      acc_ok = acc_valid_i && acc_ready_o;
      tick();
      if (acc_ok) sent++;
    end
    acc_valid_i = 1'b0;
    out_ready_i = 1'b1;
    chk("stream_count", 64'(recv), 64'd10);
    tick();
    chk("stream_drained", out_valid_o, 1'b0);

    // Kernel / pixel counters over two 4-pixel kernels
    do_reset();
    chk("cnt_k_start", kernel_idx_o, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      acc_valid_i = 1'b1;
      acc_data_i  = 32'(k * 256);
      bias_i      = 32'(k);
      tick();
      chk($sformatf("cnt_next_bias_%0d", k), next_bias_o, (k == 4 || k == 8) ? 1'b1 : 1'b0);
      chk($sformatf("cnt_done_%0d", k), done_o, (k == 8) ? 1'b1 : 1'b0);
      chk($sformatf("cnt_kernel_%0d", k), kernel_idx_o, (k >= 4 && k < 8) ? 1'b1 : 1'b0);
    end
    acc_valid_i = 1'b0;
    tick();
    chk("cnt_next_bias_idle", next_bias_o, 1'b0);
    chk("cnt_done_idle", done_o, 1'b0);

    // Reset with beats in flight: 5 beats leave pixel=1, kernel=1
    tick();
    for (int k = 0; k < 5; k++) begin
      acc_valid_i = 1'b1;
      acc_data_i  = 32'd2560;
      bias_i      = '0;
      tick();
    end
    acc_valid_i = 1'b0;
    chk("pre_rst_valid", out_valid_o, 1'b1);
    chk("pre_rst_kernel", kernel_idx_o, 1'b1);
    reset_i = 1'b0;
    #1;
    chk("async_rst_valid", out_valid_o, 1'b0);
    chk("async_rst_data", out_data_o, 8'd0);
    chk("async_rst_kernel", kernel_idx_o, 1'b0);
    tick();
    reset_i = 1'b1;
    tick();
    chk("post_rst_flush0", out_valid_o, 1'b0);
    tick();
    chk("post_rst_flush1", out_valid_o, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      acc_valid_i = 1'b1;
      acc_data_i  = 32'd512;
      bias_i      = '0;
      tick();
      chk($sformatf("post_rst_next_bias_%0d", k), next_bias_o, (k == 4) ? 1'b1 : 1'b0);
      chk($sformatf("post_rst_kernel_%0d", k), kernel_idx_o, (k == 4) ? 1'b1 : 1'b0);
    end
    acc_valid_i = 1'b0;
    tick();
    chk("post_rst_data", out_data_o, 8'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
